// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer and flush.
// Ports: clk, rst, flush | in_valid/in_ready/in_inst/in_sel/in_tag | out_valid/out_ready/out_imm/out_tag
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
);

  logic             r_m_valid;
  logic [XLEN-1:0]  r_m_imm;
  logic [TAG_W-1:0] r_m_tag;
  logic             r_k_valid;
  logic [XLEN-1:0]  r_k_imm;
  logic [TAG_W-1:0] r_k_tag;

  logic [XLEN-1:0]  w_imm;
  logic [5:0]       w_shamt;
  logic             w_fire;
  logic             w_drain;
  logic             w_unused;

  // opcode bits never contribute to an immediate
  assign w_unused = ^in_inst[6:0];

  // bit 5 of shamt only exists on RV64
  assign w_shamt = {(XLEN == 64) & in_inst[25], in_inst[24:20]};

  always_comb begin
    w_imm = '0;
    unique case (in_sel)
      3'd0: w_imm = XLEN'($signed(in_inst[31:20]));
      3'd1: w_imm = XLEN'($signed({in_inst[31:25],
                                   in_inst[11:7]}));
      3'd2: w_imm = XLEN'($signed({in_inst[31], in_inst[7],
                                   in_inst[30:25],
                                   in_inst[11:8], 1'b0}));
      3'd3: w_imm = XLEN'($signed({in_inst[31:12],
                                   12'b0}));
      3'd4: w_imm = XLEN'($signed({in_inst[31],
                                   in_inst[19:12],
                                   in_inst[20],
                                   in_inst[30:21], 1'b0}));
      3'd5: w_imm = XLEN'(in_inst[19:15]);
      3'd6: w_imm = XLEN'(w_shamt);
      3'd7: w_imm = '0;
    endcase
  end

  assign in_ready  = !r_k_valid & !rst;
  assign w_fire    = in_valid & in_ready;
  assign w_drain   = r_m_valid & out_ready;
  assign out_valid = r_m_valid;
  assign out_imm   = r_m_imm;
  assign out_tag   = r_m_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_imm   <= '0;
      r_m_tag   <= '0;
      r_k_valid <= 1'b0;
      r_k_imm   <= '0;
      r_k_tag   <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_k_valid <= 1'b0;
    end else if (r_k_valid) begin
      // in_ready is low here, so no input can arrive
      if (w_drain) begin
        r_m_valid <= 1'b1;
        r_m_imm   <= r_k_imm;
        r_m_tag   <= r_k_tag;
        r_k_valid <= 1'b0;
      end
    end else if (!r_m_valid || w_drain) begin
      r_m_valid <= w_fire;
      if (w_fire) begin
        r_m_imm <= w_imm;
        r_m_tag <= in_tag;
      end
    end else if (w_fire) begin
      r_k_valid <= 1'b1;
      r_k_imm   <= w_imm;
      r_k_tag   <= in_tag;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe, XLEN=32 and XLEN=64 in lockstep.
// Directed vectors, backpressure, flush, reset, then random traffic.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [2:0]  in_sel;
  logic [4:0]  in_tag;
  logic        rdy32, rdy64, ov32, ov64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_tag(tag64)
  );

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic [4:0]  tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // reference: immediate value as a plain integer
  function automatic exp_t mk(input logic [31:0] inst,
                              input logic [2:0] sel,
                              input logic [4:0] tag);
    exp_t   e;
    longint u;
    longint v;
    u = longint'({32'b0, inst});
    v = 0;
    case (sel)
      3'd0: begin
        v = u >> 20;
        if (v >= 2048) v = v - 4096;
      end
      3'd1: begin
        v = ((u >> 25) << 5) + ((u >> 7) & 31);
        if (v >= 2048) v = v - 4096;
      end
      3'd2: begin
        v = ((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048
          + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
        if (v >= 4096) v = v - 8192;
      end
      3'd3: begin
        v = u & 64'hFFFF_F000;
        if (v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
      end
      3'd4: begin
        v = ((u >> 31) & 1) * 1048576
          + ((u >> 12) & 255) * 4096
          + ((u >> 20) & 1) * 2048
          + ((u >> 21) & 1023) * 2;
        if (v >= 1048576) v = v - 2097152;
      end
      3'd5: v = (u >> 15) & 31;
      3'd6: v = (u >> 20) & 63;
      default: v = 0;
    endcase
    e.e64 = v;
    e.e32 = v[31:0];
    if (sel == 3'd6) e.e32 = 32'((u >> 20) & 31);
    e.tag = tag;
    return e;
  endfunction

  // collector: latch the handshake mid-cycle, apply at the edge
  logic s_fire = 1'b0;
  logic s_clr  = 1'b1;
  exp_t s_item;

  always @(negedge clk) begin
    s_clr  = rst | flush;
    s_fire = in_valid & rdy32 & !rst & !flush;
    s_item = mk(in_inst, in_sel, in_tag);
  end

  always @(posedge clk) begin
    if (s_clr) q.delete();
    else if (s_fire) q.push_back(s_item);
  end

  // monitor
  always @(negedge clk) begin
    exp_t e;
    chk("ready_64_vs_32", rdy64, rdy32);
    if (ov32 || ov64) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out: tag %0d, none pending",
                 tag32);
      end else begin
        e = q[0];
        chk("imm32", imm32, e.e32);
        chk("tag32", tag32, e.tag);
        chk("valid64", ov64, ov32);
        chk("imm64", imm64, e.e64);
        chk("tag64", tag64, e.tag);
        if (out_ready && ov32) void'(q.pop_front());
      end
    end
  end

  task automatic drive(input logic [31:0] inst,
                       input logic [2:0] sel,
                       input logic [4:0] tag);
    in_valid = 1'b1;
    in_inst  = inst;
    in_sel   = sel;
    in_tag   = tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_check(input logic [31:0] inst,
                            input logic [2:0] sel,
                            input logic [4:0] tag,
                            input logic [31:0] e32,
                            input logic [63:0] e64);
    int n;
    n = 0;
    out_ready = 1'b1;
    drive(inst, sel, tag);
    while (!rdy32 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("FAIL accept_timeout: tag %0d not taken", tag);
    end
    tick();
    in_valid = 1'b0;
    chk("dir_valid", ov32, 1'b1);
    chk("dir_imm32", imm32, e32);
    chk("dir_imm64", imm64, e64);
    chk("dir_tag", tag32, tag);
  endtask

  logic [31:0] held;

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_inst = '0; in_sel = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid32", ov32, 1'b0);
    chk("rst_valid64", ov64, 1'b0);
    chk("rst_imm32", imm32, 32'h0);
    chk("rst_imm64", imm64, 64'h0);
    chk("rst_tag", tag32, 5'd0);
    chk("rst_ready", rdy32, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", rdy32, 1'b1);

    send_check(32'hFFF00093, 3'd0, 5'd1,
               32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    send_check(32'hFE000EE3, 3'd2, 5'd2,
               32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    send_check(32'hFE000EE3, 3'd7, 5'd3, 32'h0, 64'h0);
    send_check(32'h800000B7, 3'd3, 5'd4,
               32'h80000000, 64'hFFFFFFFF80000000);
    send_check(32'h03F01093, 3'd6, 5'd5, 32'h1F, 64'h3F);
    send_check(32'h3400F073, 3'd5, 5'd6, 32'h1, 64'h1);
    send_check(32'hFE112E23, 3'd1, 5'd7,
               32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    send_check(32'hFFDFF0EF, 3'd4, 5'd8,
               32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    tick();

    // backpressure
    out_ready = 1'b0;
    drive(32'h12345093, 3'd0, 5'd1);
    chk("bp_ready1", rdy32, 1'b1);
    tick();
    drive(32'h80000093, 3'd0, 5'd2);
    chk("bp_ready2", rdy32, 1'b1);
    tick();
    drive(32'h7FF00093, 3'd0, 5'd3);
    chk("bp_ready3", rdy32, 1'b0);
    chk("bp_tag_hold", tag32, 5'd1);
    held = imm32;
    repeat (2) begin
      tick();
      chk("bp_tag_stable", tag32, 5'd1);
      chk("bp_imm_stable", imm32, held);
      chk("bp_stall", rdy32, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_out2", tag32, 5'd2);
    chk("bp_out2_valid", ov32, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp_out3", tag32, 5'd3);
    tick();
    chk("bp_empty", ov32, 1'b0);

    // flush with both entries full
    out_ready = 1'b0;
    drive(32'h00100093, 3'd0, 5'd4);
    tick();
    drive(32'h00200093, 3'd0, 5'd5);
    tick();
    chk("fl_full", rdy32, 1'b0);
    drive(32'h00700093, 3'd0, 5'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid32", ov32, 1'b0);
    chk("fl_valid64", ov64, 1'b0);
    chk("fl_ready", rdy32, 1'b1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("fl_no_tag7", ov32, 1'b0);

    // reset mid-stream with K full
    out_ready = 1'b0;
    drive(32'hABC00093, 3'd0, 5'd8);
    tick();
    drive(32'h00900093, 3'd0, 5'd9);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mr_ready_in_rst", rdy32, 1'b0);
    tick();
    chk("mr_valid", ov32, 1'b0);
    chk("mr_imm32", imm32, 32'h0);
    chk("mr_imm64", imm64, 64'h0);
    chk("mr_tag", tag32, 5'd0);
    chk("mr_tag64", tag64, 5'd0);
    rst = 1'b0;
    #1;
    chk("mr_ready_after", rdy32, 1'b1);
    send_check(32'h00500093, 3'd0, 5'd10, 32'h5, 64'h5);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_inst   = $urandom;
      in_sel    = 3'($urandom % 8);
      in_tag    = 5'($urandom);
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      rst       = ($urandom % 150) == 0;
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_queue", 64'(q.size()), 64'd0);
    tick();
    chk("drain_idle", ov32, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
